dmem_responder: RTL and testbench
=================================

// Module: dmem_responder
// PURPOSE
// Responder (slave) end of the data-memory interface driven by the pipeline's Memory stage.
// Accepts one load/store request at a time, models a word-organised data RAM with
// parameterised access latency, and returns a single-cycle response.
// Drives a busy/stall flag to the hazard unit so the M stage holds until the access completes.
// PARAMETERS
// DEPTH_WORDS  1024  number of 32-bit words in the RAM; valid byte addresses are 0 .. DEPTH_WORDS*4-1
// WAIT_CYCLES  2     extra access cycles between request accept and response (0 allowed)
// PORTS
// clk        in   1   clock, all state updates on rising edge
// rst        in   1   synchronous, active-low reset
// req_valid  in   1   M-stage request present
// req_we     in   1   1 = store, 0 = load
// req_addr   in   32  byte address; addr[1:0] ignored (lane alignment done upstream)
// req_wdata  in   32  store data, already lane-aligned
// req_be     in   4   byte enables for stores, bit i -> bits [8i+7:8i]
// req_ready  out  1   request accepted this cycle when req_valid & req_ready
// rsp_valid  out  1   one-cycle response pulse
// rsp_rdata  out  32  full word read data (load); 0 for stores and errors
// rsp_err    out  1   access out of range; qualified by rsp_valid
// busy       out  1   stall request to hazard unit
// BEHAVIOUR
// - FSM states: IDLE, WAIT, RESP. rst low: state=IDLE, counter=0, rsp_valid=0, rsp_rdata=0, rsp_err=0;
//   req_ready=0 and busy=0 while rst low. RAM contents are not reset.
// - req_ready = (state==IDLE). busy = (state==IDLE & req_valid) | (state==WAIT). busy=0 in RESP.
// - IDLE: on req_valid, latch we/addr/wdata/be and err = (req_addr>>2) >= DEPTH_WORDS.
//   WAIT_CYCLES==0 -> RESP; else -> WAIT with counter = WAIT_CYCLES-1.
// - WAIT: counter==0 -> RESP, else counter decrements. WAIT lasts exactly WAIT_CYCLES cycles.
// - Commit edge: the clock edge entering RESP.
//   - Store: writes the enabled bytes at word addr[clog2(DEPTH_WORDS)+1:2], unless err.
//   - Load: rsp_rdata <= RAM word, or 0 if err.
// - RESP: rsp_valid=1 and rsp_err=latched err for exactly one cycle; next state IDLE; then rsp_valid/rsp_err/rsp_rdata return to 0.
// - Latency: request accepted at cycle T -> rsp_valid at cycle T+WAIT_CYCLES+1.
// - Inputs after accept are ignored; deasserting req_valid in WAIT does not cancel the access.
// - A req_valid still high in RESP (the same held instruction) is NOT re-accepted.
//   The next request is accepted only in the following IDLE cycle.
// - Store with req_be=0: no RAM change, normal response, rsp_err per range check.
// - Err access: RAM unmodified, rsp_rdata=0, rsp_err=1.
// - Read-after-write: a load issued after a store's response returns the updated word.
// - Reset asserted mid-operation (IDLE-accept or WAIT) before the commit edge:
//   - no RAM write, no rsp_valid, state IDLE;
//   - req_ready=1 the first cycle rst is high.
// TESTING
// 1 WAIT_CYCLES=2: store 0x10 data 0xDEADBEEF be 1111, accepted cyc 0
//   -> busy 1,1,1,0 on cyc 0-3, rsp_valid only cyc 3, err 0.
//   Then load 0x10 -> rsp_rdata 0xDEADBEEF.
// 2 store 0x10 data 0x0000AB00 be 0010 -> subsequent load 0x10 returns 0xDEADABEF.
// 3 store 0xFFFF to byte addr DEPTH_WORDS*4 -> rsp_err=1, rsp_rdata=0.
//   Load 0x0 afterwards is unchanged from its prior value.
// 4 req_valid held high through RESP and beyond -> exactly one response per accept.
//   Second accept occurs the cycle after RESP; req_ready=0 in WAIT and RESP.
// 5 rst low during WAIT of store 0x20 data 0x12345678 -> no rsp_valid, word 0x20 unchanged.
//   req_ready=1 first cycle after rst high.
// 6 WAIT_CYCLES=0: load accepted cyc T -> rsp_valid cyc T+1, busy=1 only cyc T.

Source files
------------

// File: rtl/dmem_responder.sv
// Data-memory responder for the M stage: word RAM with fixed access latency,
// one request in flight, single-cycle response pulse and stall flag.
module dmem_responder #(
    parameter int DEPTH_WORDS = 1024,
    parameter int WAIT_CYCLES = 2
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        req_valid,
    input  logic        req_we,
    input  logic [31:0] req_addr,
    input  logic [31:0] req_wdata,
    input  logic [3:0]  req_be,
    output logic        req_ready,
    output logic        rsp_valid,
    output logic [31:0] rsp_rdata,
    output logic        rsp_err,
    output logic        busy
);

    localparam int AW = $clog2(DEPTH_WORDS);
    localparam int CW = (WAIT_CYCLES > 1) ? $clog2(WAIT_CYCLES) : 1;
    localparam logic [CW-1:0] CNT_INIT =
        (WAIT_CYCLES > 0) ? CW'(WAIT_CYCLES - 1) : '0;
    localparam logic [32:0] LIMIT = 33'(DEPTH_WORDS) << 2;
    localparam bit NO_WAIT = (WAIT_CYCLES == 0);

    typedef enum logic [1:0] {
        S_IDLE,
        S_WAIT,
        S_RESP
    } state_t;

    state_t state;
    state_t state_n;

    logic [CW-1:0] cnt;
    logic          we_q;
    logic [AW-1:0] word_q;
    logic [31:0]   wdata_q;
    logic [3:0]    be_q;
    logic          err_q;
    logic [31:0]   rdata_q;

    logic [31:0]   mem [DEPTH_WORDS];

    logic          addr_err;
    logic          accept;
    logic          commit;
    logic          use_in;
    logic          c_we;
    logic          c_err;
    logic [AW-1:0] c_word;
    logic [31:0]   c_wdata;
    logic [3:0]    c_be;

    assign addr_err = {1'b0, req_addr} >= LIMIT;
    assign accept   = rst && (state == S_IDLE) && req_valid;
    assign commit   = rst && ((accept && NO_WAIT) ||
                              ((state == S_WAIT) && (cnt == '0)));

    // With no wait states the commit edge is the accept edge itself,
    // so the access must be taken straight from the request port.
    assign use_in  = (state == S_IDLE);
    assign c_we    = use_in ? req_we : we_q;
    assign c_err   = use_in ? addr_err : err_q;
    assign c_word  = use_in ? req_addr[AW+1:2] : word_q;
    assign c_wdata = use_in ? req_wdata : wdata_q;
    assign c_be    = use_in ? req_be : be_q;

    always_ff @(posedge clk) begin
        if (!rst) begin
            state <= S_IDLE;
        end else begin
            state <= state_n;
        end
    end

    always_comb begin
        state_n = state;
        unique case (state)
            S_IDLE: begin
                if (req_valid) begin
                    state_n = NO_WAIT ? S_RESP : S_WAIT;
                end
            end
            S_WAIT: begin
                if (cnt == '0) begin
                    state_n = S_RESP;
                end
            end
            S_RESP: begin
                state_n = S_IDLE;
            end
            default: begin
                state_n = S_IDLE;
            end
        endcase
    end

    always_comb begin
        req_ready = 1'b0;
        busy      = 1'b0;
        rsp_valid = 1'b0;
        rsp_err   = 1'b0;
        if (rst) begin
            req_ready = (state == S_IDLE);
            busy      = ((state == S_IDLE) && req_valid) ||
                        (state == S_WAIT);
            rsp_valid = (state == S_RESP);
            rsp_err   = (state == S_RESP) && err_q;
        end
    end

    assign rsp_rdata = rdata_q;

    always_ff @(posedge clk) begin
        if (!rst) begin
            cnt     <= '0;
            we_q    <= 1'b0;
            word_q  <= '0;
            wdata_q <= '0;
            be_q    <= '0;
            err_q   <= 1'b0;
        end else if (accept) begin
            cnt     <= CNT_INIT;
            we_q    <= req_we;
            word_q  <= req_addr[AW+1:2];
            wdata_q <= req_wdata;
            be_q    <= req_be;
            err_q   <= addr_err;
        end else if ((state == S_WAIT) && (cnt != '0)) begin
            cnt <= cnt - 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            rdata_q <= '0;
        end else if (commit && !c_we && !c_err) begin
            rdata_q <= mem[c_word];
        end else begin
            rdata_q <= '0;
        end
    end

    always_ff @(posedge clk) begin
        if (commit && c_we && !c_err) begin
            for (int i = 0; i < 4; i++) begin
                if (c_be[i]) begin
                    mem[c_word][8*i +: 8] <= c_wdata[8*i +: 8];
                end
            end
        end
    end

endmodule

// File: tb/tb_dmem_responder.sv
// Directed bench for dmem_responder: 2-wait-state and zero-wait instances,
// expected responses queued at accept and popped on rsp_valid.
module tb_dmem_responder;

    localparam int W = 2;
    localparam int DEPTH = 1024;

    typedef struct packed {
        logic        err;
        logic [31:0] rdata;
    } exp_t;

    logic        clk;
    logic        rst;
    logic        req_valid;
    logic        req_we;
    logic [31:0] req_addr;
    logic [31:0] req_wdata;
    logic [3:0]  req_be;
    logic        req_ready;
    logic        rsp_valid;
    logic [31:0] rsp_rdata;
    logic        rsp_err;
    logic        busy;

    logic        v0;
    logic        we0;
    logic [31:0] a0;
    logic [31:0] wd0;
    logic [3:0]  be0;
    logic        rdy0;
    logic        rv0;
    logic [31:0] rd0;
    logic        er0;
    logic        bz0;

    exp_t sb_q[$];
    exp_t sb0[$];

    int checks;
    int failures;

    dmem_responder #(
        .DEPTH_WORDS(DEPTH),
        .WAIT_CYCLES(W)
    ) dut (
        .clk(clk),
        .rst(rst),
        .req_valid(req_valid),
        .req_we(req_we),
        .req_addr(req_addr),
        .req_wdata(req_wdata),
        .req_be(req_be),
        .req_ready(req_ready),
        .rsp_valid(rsp_valid),
        .rsp_rdata(rsp_rdata),
        .rsp_err(rsp_err),
        .busy(busy)
    );

    dmem_responder #(
        .DEPTH_WORDS(DEPTH),
        .WAIT_CYCLES(0)
    ) dut0 (
        .clk(clk),
        .rst(rst),
        .req_valid(v0),
        .req_we(we0),
        .req_addr(a0),
        .req_wdata(wd0),
        .req_be(be0),
        .req_ready(rdy0),
        .rsp_valid(rv0),
        .rsp_rdata(rd0),
        .rsp_err(er0),
        .busy(bz0)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Issue one request from an IDLE cycle and follow it to its response.
    task automatic tx(input logic we, input logic [31:0] addr,
                      input logic [31:0] wd, input logic [3:0] be,
                      input logic [31:0] erd, input logic eerr,
                      input bit hold, input string tag);
        exp_t e;
        bit   got;
        req_valid = 1'b1;
        req_we    = we;
        req_addr  = addr;
        req_wdata = wd;
        req_be    = be;
        #1;
        chk({tag, "_ready_acc"}, req_ready, 1);
        chk({tag, "_busy_acc"}, busy, 1);
        sb_q.push_back('{err: eerr, rdata: erd});
        got = 0;
        for (int k = 1; k <= 8 && !got; k++) begin
            @(posedge clk);
            #1;
            if (!hold) begin
                req_valid = 1'b0;
                req_we    = 1'b0;
                req_wdata = 32'hFFFF_FFFF;
            end
            #1;
            if (k <= W + 1) begin
                chk({tag, "_busy"}, busy, (k <= W) ? 1 : 0);
                chk({tag, "_ready_busy"}, req_ready, 0);
            end
            if (rsp_valid) begin
                got = 1;
                chk({tag, "_latency"}, k, W + 1);
                if (sb_q.size() == 0) begin
                    chk({tag, "_sb_empty"}, 1, 0);
                end else begin
                    e = sb_q.pop_front();
                    chk({tag, "_rdata"}, rsp_rdata, e.rdata);
                    chk({tag, "_err"}, rsp_err, e.err);
                end
            end
        end
        if (!got) begin
            chk({tag, "_rsp_timeout"}, 0, 1);
        end
        @(posedge clk);
        #2;
        chk({tag, "_rv_after"}, rsp_valid, 0);
        chk({tag, "_rd_after"}, rsp_rdata, 0);
        chk({tag, "_ready_after"}, req_ready, 1);
    endtask

    initial begin
        exp_t e;
        checks = 0;
        failures = 0;
        rst = 1'b0;
        req_valid = 1'b0;
        req_we = 1'b0;
        req_addr = '0;
        req_wdata = '0;
        req_be = '0;
        v0 = 1'b0;
        we0 = 1'b0;
        a0 = '0;
        wd0 = '0;
        be0 = '0;

        // reset behaviour
        #1;
        req_valid = 1'b1;
        #1;
        chk("rst_ready", req_ready, 0);
        chk("rst_busy", busy, 0);
        @(posedge clk);
        @(posedge clk);
        #1;
        req_valid = 1'b0;
        #1;
        chk("rst_rv", rsp_valid, 0);
        chk("rst_rd", rsp_rdata, 0);
        chk("rst_err", rsp_err, 0);
        @(posedge clk);
        #1;
        rst = 1'b1;
        #1;
        chk("post_rst_ready", req_ready, 1);
        chk("post_rst_busy", busy, 0);

        // store/load and byte-lane merge
        tx(1, 32'h10, 32'hDEAD_BEEF, 4'b1111, 0, 0, 0, "st_full");
        tx(0, 32'h10, 0, 0, 32'hDEAD_BEEF, 0, 0, "ld_full");
        tx(1, 32'h10, 32'h0000_AB00, 4'b0010, 0, 0, 0, "st_b1");
        tx(0, 32'h10, 0, 0, 32'hDEAD_ABEF, 0, 0, "ld_b1");
        tx(1, 32'h10, 32'hFFFF_FFFF, 4'b0000, 0, 0, 0, "st_be0");
        tx(0, 32'h10, 0, 0, 32'hDEAD_ABEF, 0, 0, "ld_be0");

        // range edge and out-of-range aliasing onto word 0
        tx(1, 32'h0, 32'hCAFE_F00D, 4'b1111, 0, 0, 0, "st_w0");
        tx(1, DEPTH * 4, 32'h0000_FFFF, 4'b1111, 0, 1, 0, "st_oob");
        tx(0, DEPTH * 4, 0, 0, 0, 1, 0, "ld_oob");
        tx(0, 32'h0, 0, 0, 32'hCAFE_F00D, 0, 0, "ld_w0");
        tx(1, DEPTH * 4 - 4, 32'h600D_F00D, 4'b1111, 0, 0, 0, "st_last");
        tx(0, DEPTH * 4 - 4, 0, 0, 32'h600D_F00D, 0, 0, "ld_last");

        // request held through RESP: one response per accept
        tx(0, 32'h10, 0, 0, 32'hDEAD_ABEF, 0, 1, "ld_hold1");
        chk("hold_reaccept_ready", req_ready, 1);
        tx(0, 32'h10, 0, 0, 32'hDEAD_ABEF, 0, 0, "ld_hold2");

        // reset during WAIT cancels the store
        tx(1, 32'h20, 32'h1111_2222, 4'b1111, 0, 0, 0, "st_w20");
        req_valid = 1'b1;
        req_we = 1'b1;
        req_addr = 32'h20;
        req_wdata = 32'h1234_5678;
        req_be = 4'b1111;
        #1;
        chk("mid_rst_ready_acc", req_ready, 1);
        @(posedge clk);
        #1;
        req_valid = 1'b0;
        rst = 1'b0;
        #1;
        chk("mid_rst_ready", req_ready, 0);
        chk("mid_rst_busy", busy, 0);
        chk("mid_rst_rv", rsp_valid, 0);
        @(posedge clk);
        #1;
        rst = 1'b1;
        #1;
        chk("mid_rst_ready_rel", req_ready, 1);
        chk("mid_rst_rv_rel", rsp_valid, 0);
        for (int i = 0; i < 3; i++) begin
            @(posedge clk);
            #2;
            chk("mid_rst_no_rsp", rsp_valid, 0);
        end
        tx(0, 32'h20, 0, 0, 32'h1111_2222, 0, 0, "ld_w20");

        // zero wait states
        v0 = 1'b1;
        we0 = 1'b1;
        a0 = 32'h8;
        wd0 = 32'hA5A5_A5A5;
        be0 = 4'b1111;
        #1;
        chk("w0_st_ready", rdy0, 1);
        chk("w0_st_busy", bz0, 1);
        sb0.push_back('{err: 1'b0, rdata: 32'h0});
        @(posedge clk);
        #1;
        v0 = 1'b0;
        #1;
        chk("w0_st_rv", rv0, 1);
        chk("w0_st_busy_resp", bz0, 0);
        chk("w0_st_ready_resp", rdy0, 0);
        if (sb0.size() > 0) begin
            e = sb0.pop_front();
            chk("w0_st_rd", rd0, e.rdata);
            chk("w0_st_err", er0, e.err);
        end
        @(posedge clk);
        #1;
        v0 = 1'b1;
        we0 = 1'b0;
        #1;
        chk("w0_ld_busy", bz0, 1);
        chk("w0_ld_rv_idle", rv0, 0);
        sb0.push_back('{err: 1'b0, rdata: 32'hA5A5_A5A5});
        @(posedge clk);
        #1;
        v0 = 1'b0;
        #1;
        chk("w0_ld_rv", rv0, 1);
        chk("w0_ld_busy_resp", bz0, 0);
        if (sb0.size() > 0) begin
            e = sb0.pop_front();
            chk("w0_ld_rd", rd0, e.rdata);
            chk("w0_ld_err", er0, e.err);
        end
        @(posedge clk);
        #2;
        chk("w0_rv_after", rv0, 0);
        chk("w0_busy_after", bz0, 0);
        chk("sb_drained", sb_q.size() + sb0.size(), 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
